mul_iter: RTL and testbench
===========================

# mul_iter

Parametrised iterative shift-add multiplier, the successor to the fixed 8-bit `MUL` unit. It computes a WIDTH×WIDTH product over WIDTH+1 clock edges. A per-operation `signed_mode` input selects signed or unsigned multiplication. A `busy` flag and a one-cycle `finish` pulse allow back-to-back operations. It sits beside the lab datapath as a shared multi-cycle arithmetic unit driven by a start/finish handshake.

## Interface
- `WIDTH`, default 8, operand width in bits (≥2); the product is 2·WIDTH bits.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  request a multiply; level-sampled only while idle.
- `a`  input  WIDTH  multiplicand; sampled on the accepting edge.
- `b`  input  WIDTH  multiplier; sampled on the accepting edge.
- `signed_mode`  input  1  1 = two's-complement operands, 0 = unsigned; sampled on the accepting edge.
- `res`  output  2·WIDTH  registered product; holds its value until the next product is written.
- `finish`  output  1  registered one-cycle pulse marking a new valid `res`.
- `busy`  output  1  high when the state is not IDLE.

## Operation
- States:
  - IDLE: wait for `start`.
  - CALC: one shift-add step per cycle.
  - FIX: sign correction and result write-back.
- Accept: in IDLE with `start`=1 on edge E0:
  - latch `signed_mode` and the sign bits of `a` and `b`;
  - latch |a| and |b| as WIDTH-bit magnitudes (raw values when unsigned);
  - clear the 2·WIDTH-bit accumulator and the step counter;
  - go to CALC.
- CALC, each edge:
  - if the multiplier LSB is 1, add the shifted multiplicand into the accumulator;
  - shift the multiplicand left and the multiplier right;
  - increment the counter.
  - After WIDTH steps, go to FIX.
- FIX, one edge:
  - `res` ← negated accumulator if `signed_mode` and sign(a)≠sign(b), otherwise the accumulator;
  - `finish` ← 1;
  - go to IDLE.
- Width rules:
  - the magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), which fits in WIDTH unsigned bits;
  - all products fit in 2·WIDTH bits, so no overflow or saturation logic is needed;
  - for WIDTH=8, (−128)·(−128) = 16384.
- `start` during CALC or FIX is ignored.
- `start` held high continuously re-triggers in the IDLE cycle after FIX.
- `a`, `b` and `signed_mode` may change freely after E0.
- `rst` dominates all other inputs in any state. It forces IDLE and clears the accumulator, `res`, `finish` and `busy`. An aborted operation produces no `finish`.

## Timing
- Reset values: `res`=0, `finish`=0, `busy`=0, state IDLE.
- `busy` rises on E0 and falls on E(WIDTH+1).
- `res` updates and `finish` rises on E(WIDTH+1). `finish` falls on E(WIDTH+2).
- Latency is WIDTH+1 edges from accept to `finish`. For WIDTH=8, `finish` is high in the cycle after the 9th edge.
- Back-to-back: the cycle in which `finish` is high is an IDLE cycle. A `start` sampled at E(WIDTH+2) is accepted, giving a throughput of one product per WIDTH+2 cycles.
- `res` stays stable between `finish` pulses. It is not disturbed by a new accept before the next FIX.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - at each CALC edge, if the remaining multiplier is 0, skip the step and go directly to FIX;
  - latency becomes min(k+3, WIDTH+1) edges, where k is the index of the top set bit of |b|;
  - |b| = 0 gives a latency of 2 edges.
- Macro undefined: always WIDTH CALC steps, with latency fixed at WIDTH+1.
- `res`, `finish` pulse width and reset behaviour are identical in both builds.

## Structure
- Shared package `mul_pkg` holds:
  - the state enumeration (IDLE, CALC, FIX);
  - a `clog2`-based counter-width localparam helper, shared with future divider blocks.
- One sub-module is natural: `mul_core`, the datapath holding the accumulator, multiplicand/multiplier shift registers and sign-fix negation. The top level keeps the FSM, counter and handshake.

## Test plan
- Reset: `rst`=1 for 2 cycles, then released → `res`=0, `finish`=0, `busy`=0. Assert `rst` mid-CALC → `busy`=0 next edge and no `finish`.
- Unsigned: WIDTH=8, `signed_mode`=0, a=200, b=150 → `res`=16'h7530 (30000), with `finish` exactly 9 edges after accept and high for 1 cycle.
- Signed:
  - a=8'hF6 (−10), b=8'd7 → `res`=16'hFFBA (−70);
  - a=8'h80, b=8'h80 → `res`=16'h4000.
- Start held 2 cycles, then 5 random pairs using seed 2024: exactly one `finish` per request, `res` matching a reference model, and `start` ignored while `busy`.
- Back-to-back: `start` held high continuously → new accepts at E0, E10, E20…, with `res` updating only on the `finish` cycles.
- With `MUL_EARLY_EXIT_EN`:
  - b=0 → `finish` after 2 edges with `res`=0;
  - b=1, a=37 → `finish` after 3 edges with `res`=37;
  - b=8'h80, unsigned → `finish` after 9 edges.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative arithmetic units (multiplier now,
// divider later): FSM state encoding and a step-counter width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Bits needed for a counter that must hold the values 0..steps.
  function automatic int cnt_width(input int steps);
    return (steps < 2) ? 1 : $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/mul_core.sv
// Shift-add datapath for mul_iter: magnitude capture, accumulator,
// multiplicand/multiplier shift registers and the final sign fix.
module mul_core
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] res,
  output logic               mplier_zero
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic [PW-1:0]    acc_p0;
  logic             neg_p0;

  // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? WIDTH'(-sv) : v;
  endfunction

  // Restore the product sign; every product fits in PW bits, so no
  // saturation is needed.
  function automatic logic [PW-1:0] sign_fix(input logic [PW-1:0] v,
                                             input logic neg);
    logic signed [PW-1:0] sv;
    sv = $signed(v);
    return neg ? PW'(-sv) : v;
  endfunction

  // Operand capture and per-step shifting of multiplicand and multiplier.
  always_ff @(posedge clk) begin
    if (load) begin
      mcand_p0  <= {{WIDTH{1'b0}}, magnitude(a, signed_mode & a[WIDTH-1])};
      mplier_p0 <= magnitude(b, signed_mode & b[WIDTH-1]);
      neg_p0    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  // Accumulator: cleared on accept, conditionally adds on each step.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      acc_p0 <= '0;
    end else if (step && mplier_p0[0]) begin
      acc_p0 <= acc_p0 + mcand_p0;
    end
  end

  // Result register: written only by the sign-fix cycle, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
    end else if (fix) begin
      res <= sign_fix(acc_p0, neg_p0);
    end
  end

  assign mplier_zero = (mplier_p0 == '0);

endmodule

// File: rtl/mul_iter.sv
// Iterative WIDTH x WIDTH shift-add multiplier with start/finish handshake
// and per-operation signed/unsigned selection.
// Optional build macro MUL_EARLY_EXIT_EN: leave CALC as soon as the
// remaining multiplier is zero instead of always running WIDTH steps.
module mul_iter
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] res,
  output logic               finish,
  output logic               busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load, step, fix;
  logic             mplier_zero;

  mul_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .fix         (fix),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .res         (res),
    .mplier_zero (mplier_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath strobes; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (EARLY_EXIT && mplier_zero) begin
          state_nxt = FIX;
        end else begin
          step = 1'b1;
          if (cnt == LAST) state_nxt = FIX;
        end
      end
      FIX: begin
        fix       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Step counter: cleared on accept, one count per shift-add step.
  always_ff @(posedge clk) begin
    if (rst || load) cnt <= '0;
    else if (step)   cnt <= cnt + CNT_W'(1);
  end

  // One-cycle completion pulse, aligned with the result write.
  always_ff @(posedge clk) begin
    if (rst) finish <= 1'b0;
    else     finish <= fix;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter (WIDTH=8): reset, signed/unsigned products,
// latency, start masking while busy and back-to-back throughput.
module tb_mul_iter;

  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic        signed_mode;
  logic [15:0] res;
  logic        finish, busy;

  int errors = 0;
  int checks = 0;

  mul_iter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .res         (res),
    .finish      (finish),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] av, input logic [7:0] bv,
                                          input logic sm);
    logic signed [15:0] sa, sb;
    if (sm) begin
      sa = {{8{av[7]}}, av};
      sb = {{8{bv[7]}}, bv};
      return 16'(sa * sb);
    end
    return {8'h00, av} * {8'h00, bv};
  endfunction

  function automatic int exp_lat(input logic [7:0] bv, input logic sm);
    logic [7:0] mag;
    int k;
    mag = (sm && bv[7]) ? (~bv + 8'd1) : bv;
`ifdef MUL_EARLY_EXIT_EN
    if (mag == 8'd0) return 2;
    k = 0;
    for (int i = 0; i < 8; i++) if (mag[i]) k = i;
    return (k + 3 < 9) ? k + 3 : 9;
`else
    k = int'(mag);
    return 9 + k * 0;
`endif
  endfunction

  // One request: operands scrambled after accept; optional start held an
  // extra edge and an extra start pulse while busy.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm, input int hold, input bit pulse);
    int n;
    int fins;
    logic [15:0] exp;
    exp = ref_mul(av, bv, sm);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    tick();
    check({tag, "_busy_rise"}, busy, 1);
    if (hold < 2) start = 1'b0;
    a = ~av; b = bv ^ 8'h5A; signed_mode = ~sm;
    n = 0;
    while (n < 30) begin
      tick();
      n++;
      start = (pulse && busy && n == 3);
      if (finish) break;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, exp_lat(bv, sm));
    check({tag, "_res"}, res, exp);
    check({tag, "_busy_fall"}, busy, 0);
    fins = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (finish) fins++;
    end
    check({tag, "_one_finish"}, fins, 0);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_res_hold"}, res, exp);
  endtask

  initial begin
    logic [31:0] st;
    logic [15:0] prev;
    logic [15:0] er;
    int fins;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_res", res, 16'h0000);
    check("rst_finish", finish, 0);
    check("rst_busy", busy, 0);
    tick();
    check("idle_busy", busy, 0);

    run_op("u200x150", 8'd200, 8'd150, 1'b0, 1, 1'b0);

    // Abort mid-CALC: no finish, outputs cleared.
    a = 8'd200; b = 8'd150; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_finish", finish, 0);
    check("abort_res", res, 16'h0000);
    fins = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (finish) fins++;
    end
    check("abort_no_finish", fins, 0);

    run_op("s_m10x7",   8'hF6, 8'd7,  1'b1, 1, 1'b0);
    run_op("s_m128sq",  8'h80, 8'h80, 1'b1, 1, 1'b0);
    run_op("s_5xm3",    8'd5,  8'hFD, 1'b1, 1, 1'b0);
    run_op("u_b0",      8'h55, 8'h00, 1'b0, 1, 1'b0);
    run_op("u_37x1",    8'd37, 8'd1,  1'b0, 1, 1'b0);
    run_op("u_ffx80",   8'hFF, 8'h80, 1'b0, 1, 1'b0);
    run_op("u_ffxff",   8'hFF, 8'hFF, 1'b0, 1, 1'b0);

    st = 32'd2024;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] ra, rb;
      st = st * 32'd1103515245 + 32'd12345;
      ra = st[23:16];
      st = st * 32'd1103515245 + 32'd12345;
      rb = st[23:16];
      run_op($sformatf("rnd%0d", i), ra, rb, st[30], 2, 1'b1);
    end

    // Start held high: accepts at E0, E10, E20.
    prev = res;
    a = 8'd3; b = 8'h81; signed_mode = 1'b0; start = 1'b1;
    tick();
    a = 8'd7; b = 8'h90;
    for (int n = 1; n <= 29; n++) begin
      tick();
      if (n == 10) begin
        a = 8'd2; b = 8'hC0;
      end
      if (n < 9)       er = prev;
      else if (n < 19) er = 16'd387;
      else if (n < 29) er = 16'd1008;
      else             er = 16'd384;
      check($sformatf("b2b_fin_%0d", n), finish, (n % 10 == 9));
      check($sformatf("b2b_busy_%0d", n), busy, (n % 10 != 9));
      check($sformatf("b2b_res_%0d", n), res, er);
    end
    start = 1'b0;
    tick();
    tick();
    check("b2b_stop_busy", busy, 0);
    check("b2b_stop_finish", finish, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
